delay_timer_arbiter: RTL and testbench

Shares one tick-based countdown engine among several requesters (e.g. game round sequencer, servo positioner, buzzer) that each need a timed delay expressed in 100 kHz ticks. Requests are arbitrated round-robin. The winner's delay is loaded into the engine, counted down against an internal prescaled tick, and completion is signalled with a one-cycle DONE pulse. It sits between the 50 MHz board clock domain and the game-control FSMs, and replaces per-requester timers.

---
 rtl/dt_pkg.sv | 45 ++++
 rtl/tick_prescaler.sv | 34 +++
 rtl/delay_timer_arbiter.sv | 108 ++++++++++
 tb/tb_delay_timer_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and helpers for the delay_timer_arbiter slice: FSM states,
// prescaler sizing and the round-robin selection functions.
package dt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } dt_state_t;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  function automatic int calc_prescale(input int clock_freq, input int tick_freq);
    return clock_freq / tick_freq;
  endfunction

  function automatic int calc_ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  localparam int DEFAULT_PRESCALE = calc_prescale(50_000_000, 100_000);
  localparam int DEFAULT_PS_WIDTH = calc_ps_width(DEFAULT_PRESCALE);

  // First requester at or after ptr, scanning upward with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr,
                                              input int                 num_req);
    logic [IDX_W-1:0] pick;
    int               sum;
    pick = ptr;
    for (int k = num_req - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= num_req) sum = sum - num_req;
      if (req[sum]) pick = IDX_W'(sum);
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] owner,
                                              input int               num_req);
    return (int'(owner) == num_req - 1) ? '0 : owner + 1'b1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clearable, enabled modulo-PRESCALE counter; tick is high for the one
// cycle in which the count sits at PRESCALE-1 while enabled.
module tick_prescaler
  import dt_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int CNT_W    = calc_ps_width(PRESCALE)
) (
  input  logic FD_CLOCK_IN,
  input  logic FD_RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge FD_CLOCK_IN or posedge FD_RESET) begin
    if (FD_RESET) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/delay_timer_arbiter.sv
// Round-robin shared countdown engine. Optional per-requester cancel is
// compiled in when DT_ABORT_EN is defined.
module delay_timer_arbiter
  import dt_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int TICK_FREQ   = 100_000,
  parameter int DELAY_WIDTH = 20
) (
  input  logic                           FD_CLOCK_IN,
  input  logic                           FD_RESET,
  input  logic [NUM_REQ-1:0]             DT_REQ,
  input  logic [NUM_REQ*DELAY_WIDTH-1:0] DT_DELAY,
`ifdef DT_ABORT_EN
  input  logic [NUM_REQ-1:0]             DT_ABORT,
`endif
  output logic [NUM_REQ-1:0]             DT_GRANT,
  output logic [NUM_REQ-1:0]             DT_DONE,
  output logic                           DT_BUSY,
  output logic [DELAY_WIDTH-1:0]         DT_REMAIN
);

  localparam int PRESCALE = calc_prescale(CLOCK_FREQ, TICK_FREQ);
  localparam int PS_W     = calc_ps_width(PRESCALE);

  dt_state_t             state;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      winner;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DELAY_WIDTH-1:0] win_delay;
  logic                  tick;
  logic                  last_tick;
  logic                  abort_hit;

  assign winner     = rr_pick(MAX_REQ'(DT_REQ), ptr, NUM_REQ);
  assign win_onehot = NUM_REQ'(1) << winner;
  assign win_delay  = DT_DELAY[int'(winner)*DELAY_WIDTH +: DELAY_WIDTH];
  assign last_tick  = tick && (DT_REMAIN == DELAY_WIDTH'(1));

`ifdef DT_ABORT_EN
  logic [MAX_REQ-1:0] abort_ext;
  assign abort_ext = MAX_REQ'(DT_ABORT);
  assign abort_hit = abort_ext[owner];
`else
  assign abort_hit = 1'b0;
`endif

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (PS_W)
  ) u_prescaler (
    .FD_CLOCK_IN (FD_CLOCK_IN),
    .FD_RESET    (FD_RESET),
    .clear       (state != COUNT),
    .enable      (state == COUNT),
    .tick        (tick)
  );

  always_ff @(posedge FD_CLOCK_IN or posedge FD_RESET) begin
    if (FD_RESET) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      DT_GRANT  <= '0;
      DT_DONE   <= '0;
      DT_BUSY   <= 1'b0;
      DT_REMAIN <= '0;
    end else begin
      DT_DONE <= '0;
      case (state)
        IDLE: begin
          if (|DT_REQ) begin
            owner     <= winner;
            DT_REMAIN <= win_delay;
            DT_GRANT  <= win_onehot;
            DT_BUSY   <= 1'b1;
            state     <= COUNT;
          end
        end
        COUNT: begin
          // Reaching zero (or the tick that gets there) beats a concurrent abort.
          if (DT_REMAIN == '0) begin
            DT_DONE <= DT_GRANT;
            state   <= DONE;
          end else if (abort_hit && !last_tick) begin
            DT_GRANT  <= '0;
            DT_BUSY   <= 1'b0;
            DT_REMAIN <= '0;
            ptr       <= rr_next(owner, NUM_REQ);
            state     <= IDLE;
          end else if (tick) begin
            DT_REMAIN <= DT_REMAIN - 1'b1;
          end
        end
        DONE: begin
          DT_GRANT <= '0;
          DT_BUSY  <= 1'b0;
          ptr      <= rr_next(owner, NUM_REQ);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Scoreboard bench for delay_timer_arbiter with PRESCALE = 5; abort cases
// are included when DT_ABORT_EN is defined.
module tb_delay_timer_arbiter;

  localparam int N  = 4;
  localparam int DW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] dly = '0;
`ifdef DT_ABORT_EN
  logic [N-1:0]    abort = '0;
`endif
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [DW-1:0]   remain;

  delay_timer_arbiter #(
    .NUM_REQ     (N),
    .CLOCK_FREQ  (500),
    .TICK_FREQ   (100),
    .DELAY_WIDTH (DW)
  ) dut (
    .FD_CLOCK_IN (clk),
    .FD_RESET    (rst),
    .DT_REQ      (req),
    .DT_DELAY    (dly),
`ifdef DT_ABORT_EN
    .DT_ABORT    (abort),
`endif
    .DT_GRANT    (grant),
    .DT_DONE     (done),
    .DT_BUSY     (busy),
    .DT_REMAIN   (remain)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Latencies are measured in cycles from the grant rise; -1 means "none".
  typedef struct {
    logic [N-1:0] grant;
    int           done_lat;
    int           fall_lat;
    int           gap;
  } job_t;

  job_t exp_q[$];

  bit   mon_active = 1'b0;
  bit   mon_saw_done = 1'b0;
  job_t mon_cur;
  int   mon_g_cyc = 0;
  int   mon_last_done = -1000;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!mon_active) begin
        if (done != '0) check("stray_done", 32'(done), 32'd0);
        if (grant != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 32'(grant), 32'd0);
          end else begin
            mon_cur      = exp_q.pop_front();
            mon_active   = 1'b1;
            mon_saw_done = 1'b0;
            mon_g_cyc    = cyc;
            check("grant", 32'(grant), 32'(mon_cur.grant));
            check("busy_rise", 32'(busy), 32'd1);
            if (mon_cur.gap > 0) check("idle_gap", 32'(cyc - mon_last_done), 32'(mon_cur.gap));
          end
        end
      end else begin
        if (done != '0) begin
          mon_saw_done  = 1'b1;
          mon_last_done = cyc;
          check("done_vec", 32'(done), 32'(mon_cur.grant));
          check("done_lat", 32'(cyc - mon_g_cyc), 32'(mon_cur.done_lat));
        end
        if (grant == '0) begin
          mon_active = 1'b0;
          check("busy_fall", 32'(busy), 32'd0);
          check("done_seen", 32'(mon_saw_done), 32'(mon_cur.done_lat >= 0));
          if (mon_cur.fall_lat >= 0) check("fall_lat", 32'(cyc - mon_g_cyc), 32'(mon_cur.fall_lat));
        end else begin
          check("grant_hold", 32'(grant), 32'(mon_cur.grant));
        end
      end
    end
  end

  task automatic set_delay(input int idx, input int d);
    dly[idx*DW +: DW] = DW'(d);
  endtask

  task automatic wait_grant(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant != '0) return;
    end
    check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && grant == '0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_remain"}, 32'(remain), 32'd0);
  endtask

  initial begin : stimulus
    logic [N-1:0] prev;
    int           rises;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request, D=3: REMAIN steps every 5 cycles, DONE at +16.
    set_delay(0, 3);
    exp_q.push_back(job_t'{4'b0001, 16, 17, 0});
    req = 4'b0001;
    wait_grant(4);
    req = '0;
    check("remain_t0", 32'(remain), 32'd3);
    repeat (5) @(negedge clk);
    check("remain_t1", 32'(remain), 32'd2);
    repeat (5) @(negedge clk);
    check("remain_t2", 32'(remain), 32'd1);
    repeat (5) @(negedge clk);
    check("remain_t3", 32'(remain), 32'd0);
    wait_idle(40);

    // Zero delay on requester 2.
    set_delay(2, 0);
    exp_q.push_back(job_t'{4'b0100, 1, 2, 0});
    req = 4'b0100;
    wait_grant(4);
    req = '0;
    @(negedge clk);
    check("busy_d0_g1", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_d0_g2", 32'(busy), 32'd0);
    wait_idle(10);

    // Reset between jobs brings PTR back to 0.
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_pulse");
    rst = 1'b0;
    @(negedge clk);

    // Contention: all four held, D=1 each.
    for (int i = 0; i < N; i++) set_delay(i, 1);
    exp_q.push_back(job_t'{4'b0001, 6, 7, 0});
    exp_q.push_back(job_t'{4'b0010, 6, 7, 2});
    exp_q.push_back(job_t'{4'b0100, 6, 7, 2});
    exp_q.push_back(job_t'{4'b1000, 6, 7, 2});
    exp_q.push_back(job_t'{4'b0001, 6, 7, 2});
    req   = 4'b1111;
    prev  = '0;
    rises = 0;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      @(negedge clk);
      if (grant != '0 && prev == '0) rises++;
      prev = grant;
    end
    req = '0;
    check("contention_grants", 32'(rises), 32'd5);
    wait_idle(20);

    // Reset mid-job after four ticks: outputs clear at once, no DONE.
    set_delay(1, 10);
    exp_q.push_back(job_t'{4'b0010, -1, -1, 0});
    req = 4'b0010;
    wait_grant(4);
    req = '0;
    repeat (20) @(negedge clk);
    check("remain_before_reset", 32'(remain), 32'd6);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // PTR is 0 after reset, so requester 0 beats requester 3.
    set_delay(0, 1);
    set_delay(3, 1);
    exp_q.push_back(job_t'{4'b0001, 6, 7, 0});
    req = 4'b1001;
    wait_grant(4);
    req = '0;
    wait_idle(20);

`ifdef DT_ABORT_EN
    // Abort by owner at tick 2; a non-owner abort earlier has no effect.
    set_delay(3, 8);
    exp_q.push_back(job_t'{4'b1000, -1, 10, 0});
    req = 4'b1000;
    wait_grant(4);
    req = '0;
    repeat (2) @(negedge clk);
    abort = 4'b0001;
    repeat (2) @(negedge clk);
    abort = '0;
    repeat (5) @(negedge clk);
    check("remain_before_abort", 32'(remain), 32'd7);
    abort = 4'b1000;
    @(negedge clk);
    abort = '0;
    check("remain_after_abort", 32'(remain), 32'd0);
    wait_idle(10);

    // Abort coinciding with the final tick: DONE still fires.
    set_delay(3, 2);
    exp_q.push_back(job_t'{4'b1000, 11, 12, 0});
    req = 4'b1000;
    wait_grant(4);
    req = '0;
    repeat (9) @(negedge clk);
    abort = 4'b1000;
    repeat (2) @(negedge clk);
    abort = '0;
    wait_idle(10);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
